// File: rtl/striping_pkg.sv
// striping_pkg
// Shared types and constants for the multi-lane 8b/10b transmit path.
//   lane_sym_t   : one lane symbol, K flag plus data byte
//   K23_7_PAD    : control symbol used to fill unused lanes of a short stripe
//   K28_5_COM    : comma symbol used by the alignment logic
//   activeCount  : turns a lane_mode code into the number of active lanes,
//                  clamped to the physical lane count
package striping_pkg;

   typedef struct packed {
      logic       k;
      logic [7:0] data;
   } lane_sym_t;

   localparam logic [7:0] K23_7_PAD = 8'hF7;
   localparam logic [7:0] K28_5_COM = 8'hBC;

   // A lane_mode code m asks for 2^m lanes; anything wider than the
   // physical link collapses to the full link width.
   function automatic int unsigned activeCount(input int unsigned mode,
                                               input int unsigned numLanes);
      int unsigned count;
      if (mode >= 32'd31) begin
         count = numLanes;
      end else begin
         count = 32'd1 << mode;
         if (count > numLanes) begin
            count = numLanes;
         end
      end
      return count;
   endfunction

endpackage

// File: rtl/stripe_out_reg.sv
// stripe_out_reg
// Single-entry valid/ready output register. A new word may be loaded in the
// same cycle the current word is taken downstream, so a full register can
// still sustain one word per cycle.
//   clk, rst    : clock, synchronous active-high reset
//   load_i      : upstream presents a word to capture
//   data_i      : word to capture
//   ready_i     : downstream accepts the held word
//   valid_o     : a word is held
//   data_o      : held word, stable while valid_o && !ready_i
//   canLoad_o   : register is empty or draining this cycle
module stripe_out_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   input  logic         ready_i,
   output logic         valid_o,
   output logic [W-1:0] data_o,
   output logic         canLoad_o
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   assign canLoad_o = !valid_q || ready_i;
   assign valid_o   = valid_q;
   assign data_o    = data_q;

   // Next-state: a load wins over a drain, which is what lets a drain and
   // a load share one edge without out_valid dropping. Data is only ever
   // replaced by a load, so it cannot move while the word is stalled.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i && canLoad_o) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   // State register; reset clears both the flag and the payload so the
   // lane outputs read as zero straight after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/lane_byte_striper.sv
// lane_byte_striper
// Deals a serial byte stream round-robin onto the active lanes and emits one
// lane-aligned word per completed stripe for the per-lane 8b/10b encoders.
// Short final stripes are padded with PAD_SYM/PAD_K.
//   clk, rst     : clock, synchronous active-high reset
//   lane_mode    : active lanes = 2^lane_mode, clamped to NUM_LANES
//   in_data/in_k : byte and its K flag
//   in_last      : final byte of a packet, closes the stripe
//   in_valid     : byte present
//   in_ready     : byte can be accepted this cycle
//   out_data     : lane i in bits [8i+7:8i]
//   out_k        : per-lane K flag
//   out_lane_en  : lane carries a byte (inactive lanes are 0)
//   out_last     : word ends a packet
//   out_valid    : word present
//   out_ready    : downstream accepts the word
module lane_byte_striper
   import striping_pkg::*;
#(
   parameter int         NUM_LANES = 4,
   parameter logic [7:0] PAD_SYM   = K23_7_PAD,
   parameter logic       PAD_K     = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [$clog2(NUM_LANES):0] lane_mode,
   input  logic [7:0]                in_data,
   input  logic                      in_k,
   input  logic                      in_last,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [8*NUM_LANES-1:0]    out_data,
   output logic [NUM_LANES-1:0]      out_k,
   output logic [NUM_LANES-1:0]      out_lane_en,
   output logic                      out_last,
   output logic                      out_valid,
   input  logic                      out_ready
);

   // Counters are one bit wider than a lane index so they can hold the
   // full active count A (e.g. 4 for a 4-lane link).
   localparam int CNT_W  = $clog2(NUM_LANES) + 1;
   localparam int SYM_W  = $bits(lane_sym_t);
   localparam int WORD_W = NUM_LANES * SYM_W + NUM_LANES + 1;

   logic [CNT_W-1:0]            active_q, active_d;
   logic [CNT_W-1:0]            fillCount_q, fillCount_d;
   lane_sym_t [NUM_LANES-1:0]   asm_q, asm_d;
   logic                        asmLast_q, asmLast_d;
   logic                        pending_q, pending_d;

   logic [CNT_W-1:0]            activeEff;
   logic                        idle;
   logic                        accept;
   logic                        complete;
   logic                        outCanLoad;
   logic                        outLoad;
   logic                        outValid;
   lane_sym_t [NUM_LANES-1:0]   stripeWord;
   lane_sym_t [NUM_LANES-1:0]   outLanes;
   logic [NUM_LANES-1:0]        laneEn;
   logic [WORD_W-1:0]           loadWord;
   logic [WORD_W-1:0]           outWord;

   // The link width is only sampled between stripes. While idle the
   // live lane_mode is used directly so the first byte of a stripe already
   // sees the new width; once a stripe is open the latched value holds.
   assign idle      = (fillCount_q == '0) && !pending_q;
   assign activeEff = idle ? CNT_W'(activeCount(32'(lane_mode), NUM_LANES))
                           : active_q;

   // Input handshake. A stripe closes on its last active lane or on in_last.
   assign in_ready = !rst && !pending_q;
   assign accept   = in_valid && in_ready;
   assign complete = accept &&
                     (in_last || (fillCount_q == (activeEff - CNT_W'(1))));

   // Build the word as it would look if the current byte closed the stripe:
   // earlier lanes from the assembly register, the current lane from the
   // input, lanes above it padded, lanes beyond the link width zeroed.
   // When the stripe is not closing the padded lanes are simply overwritten
   // by later bytes.
   always_comb begin
      stripeWord = '0;
      laneEn     = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         laneEn[i] = (CNT_W'(i) < activeEff);
         if (!laneEn[i]) begin
            stripeWord[i] = '0;
         end else if (CNT_W'(i) < fillCount_q) begin
            stripeWord[i] = asm_q[i];
         end else if (CNT_W'(i) == fillCount_q) begin
            stripeWord[i].k    = in_k;
            stripeWord[i].data = in_data;
         end else begin
            stripeWord[i].k    = PAD_K;
            stripeWord[i].data = PAD_SYM;
         end
      end
   end

   // A pending stripe always has priority for the output register; it can
   // never coincide with a new completion because in_ready is low meanwhile.
   assign loadWord = pending_q ? {asmLast_q, laneEn, asm_q}
                               : {in_last, laneEn, stripeWord};
   assign outLoad  = outCanLoad && (pending_q || complete);

   // Next-state for the fill counter, width latch, assembly register and
   // pending flag. A completed stripe that cannot go straight to the
   // output register stays in the assembly register and raises pending.
   always_comb begin
      active_d    = activeEff;
      fillCount_d = fillCount_q;
      asm_d       = asm_q;
      asmLast_d   = asmLast_q;
      pending_d   = pending_q;

      if (accept) begin
         asm_d = stripeWord;
         if (complete) begin
            fillCount_d = '0;
            asmLast_d   = in_last;
         end else begin
            fillCount_d = fillCount_q + CNT_W'(1);
         end
      end

      if (pending_q && outCanLoad) begin
         pending_d = 1'b0;
      end else if (complete && !outCanLoad) begin
         pending_d = 1'b1;
      end
   end

   // Striping state; reset throws away any partial or pending stripe.
   always_ff @(posedge clk) begin
      if (rst) begin
         active_q    <= '0;
         fillCount_q <= '0;
         asm_q       <= '0;
         asmLast_q   <= 1'b0;
         pending_q   <= 1'b0;
      end else begin
         active_q    <= active_d;
         fillCount_q <= fillCount_d;
         asm_q       <= asm_d;
         asmLast_q   <= asmLast_d;
         pending_q   <= pending_d;
      end
   end

   stripe_out_reg #(
      .W (WORD_W)
   ) u_outReg (
      .clk       (clk),
      .rst       (rst),
      .load_i    (outLoad),
      .data_i    (loadWord),
      .ready_i   (out_ready),
      .valid_o   (outValid),
      .data_o    (outWord),
      .canLoad_o (outCanLoad)
   );

   assign out_valid   = outValid;
   assign out_last    = outWord[WORD_W-1];
   assign out_lane_en = outWord[WORD_W-2 -: NUM_LANES];
   assign outLanes    = outWord[NUM_LANES*SYM_W-1:0];

   // Split the held lane symbols into the flat data and K buses.
   always_comb begin
      out_data = '0;
      out_k    = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         out_data[8*i +: 8] = outLanes[i].data;
         out_k[i]           = outLanes[i].k;
      end
   end

endmodule

// File: tb/tb_lane_byte_striper.sv
// tb_lane_byte_striper
// Drives lane_byte_striper with directed packets and a randomized stream and
// compares every output word against a packet-level reference model.
module tb_lane_byte_striper;

   localparam int NUM_LANES = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  lane_mode;
   logic [7:0]  in_data;
   logic        in_k;
   logic        in_last;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_data;
   logic [3:0]  out_k;
   logic [3:0]  out_lane_en;
   logic        out_last;
   logic        out_valid;
   logic        out_ready;

   logic [40:0] obsWord;

   // Reference model: bytes of the open stripe, its width, and the queue of
   // completed words still owed downstream (in order).
   logic [8:0]  curBytes[$];
   int          curA;
   logic [40:0] expQ[$];
   logic [40:0] prevWord;
   bit          prevStall;

   int testCount = 0;
   int failCount = 0;

   lane_byte_striper #(
      .NUM_LANES (NUM_LANES),
      .PAD_SYM   (8'hF7),
      .PAD_K     (1'b1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .lane_mode   (lane_mode),
      .in_data     (in_data),
      .in_k        (in_k),
      .in_last     (in_last),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_data    (out_data),
      .out_k       (out_k),
      .out_lane_en (out_lane_en),
      .out_last    (out_last),
      .out_valid   (out_valid),
      .out_ready   (out_ready)
   );

   always #5 clk = ~clk;

   assign obsWord = {out_last, out_lane_en, out_k, out_data};

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Packet-level rule: width chosen when a stripe opens, word emitted when
   // the stripe reaches its width or sees in_last; missing lanes padded.
   task automatic modelAccept(input logic [7:0] d, input logic k, input logic last,
                              input int mode);
      logic [40:0] w;
      if (curBytes.size() == 0) begin
         curA = 1 << mode;
         if (curA > NUM_LANES) curA = NUM_LANES;
      end
      curBytes.push_back({k, d});
      if (curBytes.size() == curA || last) begin
         w = '0;
         w[40] = last;
         for (int i = 0; i < curA; i++) begin
            w[36+i] = 1'b1;
            if (i < curBytes.size()) begin
               w[32+i]    = curBytes[i][8];
               w[8*i +: 8] = curBytes[i][7:0];
            end else begin
               w[32+i]    = 1'b1;
               w[8*i +: 8] = 8'hF7;
            end
         end
         expQ.push_back(w);
         curBytes.delete();
      end
   endtask

   // One clock: check on the falling edge, then advance the model by
   // whatever handshakes took place at the rising edge.
   task automatic applyStimulus();
      bit inXfer, outXfer;
      logic [7:0] d;
      logic k, last;
      int mode;
      @(negedge clk);
      if (rst) begin
         checkOutput("rstInReady", in_ready, 1'b0);
      end else begin
         checkOutput("inReady", in_ready, expQ.size() < 2);
         checkOutput("outValid", out_valid, expQ.size() != 0);
         if (out_valid && expQ.size() != 0) checkOutput("word", obsWord, expQ[0]);
         if (prevStall) checkOutput("stable", obsWord, prevWord);
      end
      inXfer    = !rst && in_valid && in_ready;
      outXfer   = !rst && out_valid && out_ready;
      prevStall = !rst && out_valid && !out_ready;
      prevWord  = obsWord;
      d = in_data; k = in_k; last = in_last; mode = int'(lane_mode);
      @(posedge clk);
      if (rst) begin
         expQ.delete();
         curBytes.delete();
         prevStall = 1'b0;
      end else begin
         if (outXfer && expQ.size() != 0) void'(expQ.pop_front());
         if (inXfer) modelAccept(d, k, last, mode);
      end
      #1;
   endtask

   task automatic sendByte(input logic [7:0] d, input logic k, input logic last);
      bit done = 1'b0;
      in_valid = 1'b1; in_data = d; in_k = k; in_last = last;
      for (int c = 0; c < 20 && !done; c++) begin
         done = in_ready;
         applyStimulus();
      end
      if (!done) checkOutput("sendTimeout", 1'b0, 1'b1);
      in_valid = 1'b0; in_last = 1'b0; in_k = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      in_valid = 1'b0;
      for (int c = 0; c < n; c++) applyStimulus();
   endtask

   initial begin
      rst = 1'b1; lane_mode = 3'd2; in_data = '0; in_k = 1'b0; in_last = 1'b0;
      in_valid = 1'b0; out_ready = 1'b1; prevStall = 1'b0; curA = 1;
      #1;
      applyStimulus();
      applyStimulus();
      rst = 1'b0;
      checkOutput("resetWord", obsWord, 41'd0);
      idleCycles(2);

      // Four-lane streaming, two full stripes.
      for (int b = 1; b <= 8; b++) sendByte(8'(b), 1'b0, 1'b0);
      idleCycles(2);

      // Short packet padded with K23.7.
      sendByte(8'hA0, 1'b0, 1'b0);
      sendByte(8'hA1, 1'b0, 1'b1);
      idleCycles(2);

      // Two-lane mode.
      lane_mode = 3'd1;
      for (int b = 0; b < 4; b++) sendByte(8'h10 + 8'(b), 1'b0, 1'b0);
      idleCycles(2);

      // Backpressure: stall output while 8 bytes go in, then release.
      lane_mode = 3'd2;
      out_ready = 1'b0;
      for (int b = 0; b < 8; b++) sendByte(8'h20 + 8'(b), 1'b0, 1'b0);
      idleCycles(3);
      out_ready = 1'b1;
      for (int b = 8; b < 12; b++) sendByte(8'h20 + 8'(b), 1'b0, 1'b0);
      idleCycles(3);

      // Width change mid-stripe only affects the next stripe.
      sendByte(8'h30, 1'b0, 1'b0);
      sendByte(8'h31, 1'b0, 1'b0);
      lane_mode = 3'd0;
      sendByte(8'h32, 1'b0, 1'b0);
      sendByte(8'h33, 1'b0, 1'b0);
      sendByte(8'h34, 1'b1, 1'b0);
      sendByte(8'h35, 1'b0, 1'b0);
      idleCycles(2);

      // Reset mid-stripe drops the partial stripe.
      lane_mode = 3'd2;
      for (int b = 0; b < 3; b++) sendByte(8'h40 + 8'(b), 1'b0, 1'b0);
      rst = 1'b1;
      applyStimulus();
      rst = 1'b0;
      checkOutput("midRstWord", obsWord, 41'd0);
      sendByte(8'h55, 1'b0, 1'b1);
      idleCycles(2);

      // Randomized traffic with clamped widths and random backpressure.
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 19) == 0) lane_mode = 3'($urandom_range(0, 7));
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid  = ($urandom_range(0, 4) != 0);
         in_data   = 8'($urandom);
         in_k      = ($urandom_range(0, 7) == 0);
         in_last   = ($urandom_range(0, 7) == 0);
         applyStimulus();
      end

      // Close any open stripe and drain everything still owed.
      out_ready = 1'b1;
      sendByte(8'hEE, 1'b0, 1'b1);
      for (int c = 0; c < 20 && expQ.size() != 0; c++) idleCycles(1);
      checkOutput("drained", 64'(expQ.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/lane_byte_striper.md
# lane_byte_striper

- Sequential byte-to-lane striper for the multi-lane 8b/10b transmit path.
- Accepts a serial byte stream (data plus K flag) with a valid/ready handshake and deals bytes round-robin onto up to NUM_LANES lanes.
- Emits one lane-aligned word per completed stripe to the per-lane 8b/10b encoders, padding short final stripes with a PAD control symbol.
- The active lane count (link width) is selectable at runtime.

## Interface
Parameters:
- NUM_LANES, 4: physical lanes; power of two, 1..16.
- PAD_SYM, 8'hF7: byte placed in unfilled lanes of a final stripe (K23.7).
- PAD_K, 1'b1: K flag driven with PAD_SYM.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  reset, synchronous and active-high.
- lane_mode  in  $clog2(NUM_LANES)+1  active lanes = 2^lane_mode; values giving more than NUM_LANES clamp to NUM_LANES.
- in_data  in  8  byte to stripe.
- in_k  in  1  byte is a control (K) character.
- in_last  in  1  final byte of a packet; closes the stripe.
- in_valid  in  1  input byte present.
- in_ready  out  1  block can accept a byte this cycle.
- out_data  out  8*NUM_LANES  lane i occupies bits [8i+7:8i].
- out_k  out  NUM_LANES  per-lane K flag.
- out_lane_en  out  NUM_LANES  lane carries a byte in this word (lanes ≥ active count are 0).
- out_last  out  1  word ends a packet.
- out_valid  out  1  output word present.
- out_ready  in  1  downstream accepts the word.

## Operation
- An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Lane mode:
  - The active count A is latched from lane_mode when the block is idle: fill count 0 and no pending word.
  - A holds until that stripe is emitted. A change to lane_mode mid-stripe has no effect on that stripe.
- Fill:
  - The first byte of a stripe goes to lane 0, the next to lane 1, and so on.
  - A fill counter (0..A-1) selects the lane. It wraps to 0 when a stripe completes.
- A stripe completes when the byte written to lane A-1 is accepted, or when any byte with in_last is accepted.
- Padding: on in_last at fill index f < A-1, lanes f+1..A-1 receive PAD_SYM/PAD_K in the same cycle and out_last=1.
- Inactive lanes (index ≥ A) are driven with data 8'h00, k 0, lane_en 0.
- Completion handoff:
  - If the output register is empty or draining this cycle, the completed stripe loads into it at the same edge.
  - Otherwise the stripe is held in the assembly register with the pending flag set.
  - While pending, in_ready=0. The pending stripe moves to the output register on the first cycle the output is empty or draining.
- in_ready = !rst && !pending.
- out_data, out_k, out_lane_en and out_last are stable while out_valid && !out_ready.

## Timing
- Reset (rst=1 at an edge): out_valid=0, out_data=0, out_k=0, out_lane_en=0, out_last=0, fill count=0, pending=0, A re-latched from lane_mode at the next idle cycle. in_ready=0 while rst is high.
- Reset mid-stripe: the partial stripe is discarded and no word is emitted.
- Latency: from acceptance of the completing byte at edge t, out_valid=1 after edge t.
- Throughput:
  - With out_ready held at 1: one byte per cycle in, one word every A cycles out, no bubbles.
  - With A=1: one word per cycle.
- Backpressure: in_ready deasserts at most one stripe after the output stalls. No byte is ever dropped or duplicated.
- Simultaneous drain and complete: the output transfer and the load of the new stripe happen at the same edge, and out_valid stays 1.
- A 1-byte packet with in_last completes immediately, with A-1 PAD lanes.

## Structure
- Shared package `striping_pkg`:
  - `lane_sym_t` struct {logic k; logic [7:0] data}.
  - Constants K23_7_PAD=8'hF7 and K28_5_COM=8'hBC.
  - Function mapping lane_mode to the active count with clamping.
- One sub-module: `stripe_out_reg`, a single-entry valid/ready output register with a load-while-drain path, instantiated once for the NUM_LANES-wide lane_sym_t word plus last.
- The top level holds the fill counter, the A latch, the assembly register and the pending flag.

## Test plan
- NUM_LANES=4, lane_mode=2, out_ready=1, bytes 0x01..0x08 → two words: lanes {01,02,03,04} then {05,06,07,08}; out_lane_en=4'hF; out_last=0; out_valid one cycle after bytes 4 and 8.
- lane_mode=2, bytes 0xA0, 0xA1 with in_last on 0xA1 → one word {A0,A1,F7,F7}, out_k=4'b1100, out_last=1.
- lane_mode=1 (2 lanes), bytes 0x10..0x13 → words {10,11} and {12,13}; lanes 2–3 show data 0, lane_en 0.
- out_ready=0 while streaming 12 bytes in 4-lane mode → first word held stable; second stripe pending; in_ready=0 after byte 8. Release out_ready → words 1, 2 and 3 emitted in order with no loss.
- Change lane_mode 2→0 after byte 2 of a stripe → current stripe still completes as 4 lanes; next stripe runs in 1-lane mode (one word per byte).
- Assert rst after byte 3 of a 4-lane stripe → no word emitted, all outputs 0. Next byte 0x55 after reset lands in lane 0.
